fft_peak_finder: RTL and testbench

Downstream of the FFT core: on the rising edge of the FFT `done` flag it sweeps the positive-frequency result bins. For each bin it computes the squared magnitude and tracks the largest. It then reports the winning bin index and its magnitude to the tuner's frequency/note logic, with a one-cycle valid pulse. Bins 0 (DC) and N/2..N-1 (mirror half) are never scanned.

---
 rtl/fft_peak_finder.sv | 187 ++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: on a rising fft_done edge, sweeps bins 1..N/2-1 and reports the max |X|^2 bin.
// Optional noise gate: define PEAK_NOISE_GATE_EN to add noise_thresh / peak_found.
module fft_peak_finder #(
   parameter int bit_width = 16,
   parameter int M         = 9,
   parameter int N         = 512,
   parameter int RD_LAT    = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fft_done,
   input  logic [2*bit_width-1:0] fft_wd,
   output logic [M-1:0]           rd_adr,
   output logic                   busy,
   output logic                   peak_valid,
   output logic [M-1:0]           peak_bin,
   output logic [2*bit_width:0]   peak_mag
`ifdef PEAK_NOISE_GATE_EN
   ,
   input  logic [2*bit_width:0]   noise_thresh,
   output logic                   peak_found
`endif
);

   localparam int PW = 2*bit_width;
   localparam int CW = $clog2(RD_LAT + 3);
   localparam logic [M-1:0]  LAST_ADR  = M'(N/2 - 1);
   localparam logic [CW-1:0] DRAIN_END = CW'(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, REPORT = 2'd3} state_t;

   state_t               state_r;
   logic                 done_q_r;
   logic                 armed_r;
   logic [CW-1:0]        drain_cnt_r;
   logic                 trig_s;
   logic                 start_s;
   logic [M-1:0]         adr_pipe_r [RD_LAT];
   logic                 val_pipe_r [RD_LAT];
   logic signed [PW-1:0] re_s;
   logic signed [PW-1:0] im_s;
   logic [PW-1:0]        re2_r;
   logic [PW-1:0]        im2_r;
   logic [M-1:0]         tag1_r;
   logic [M-1:0]         tag2_r;
   logic                 val1_r;
   logic                 val2_r;
   logic [PW:0]          sum2_r;
   logic [PW:0]          max_mag_r;
   logic [PW:0]          max_mag_s;
   logic [M-1:0]         max_bin_r;
   logic [M-1:0]         max_bin_s;

   // armed_r blocks a trigger when fft_done was already high as reset was released
   assign trig_s  = fft_done & ~done_q_r & armed_r;
   assign start_s = (state_r == IDLE) & trig_s;
   assign re_s    = {{bit_width{fft_wd[PW-1]}}, fft_wd[PW-1:bit_width]};
   assign im_s    = {{bit_width{fft_wd[bit_width-1]}}, fft_wd[bit_width-1:0]};

   // Compare stage: strict greater-than so ties keep the lowest bin index.
   always_comb begin
      max_mag_s = max_mag_r;
      max_bin_s = max_bin_r;
      if (val2_r && (sum2_r > max_mag_r)) begin
         max_mag_s = sum2_r;
         max_bin_s = tag2_r;
      end else begin
         max_mag_s = max_mag_r;
         max_bin_s = max_bin_r;
      end
   end

   // Datapath: read-latency tag delay, square stage, sum stage and running max.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            adr_pipe_r[i] <= '0;
            val_pipe_r[i] <= 1'b0;
         end
         re2_r     <= '0;
         im2_r     <= '0;
         tag1_r    <= '0;
         val1_r    <= 1'b0;
         sum2_r    <= '0;
         tag2_r    <= '0;
         val2_r    <= 1'b0;
         max_mag_r <= '0;
         max_bin_r <= M'(1);
      end else begin
         adr_pipe_r[0] <= rd_adr;
         val_pipe_r[0] <= (state_r == SCAN);
         for (int i = 1; i < RD_LAT; i++) begin
            adr_pipe_r[i] <= adr_pipe_r[i-1];
            val_pipe_r[i] <= val_pipe_r[i-1];
         end
         re2_r  <= re_s * re_s;
         im2_r  <= im_s * im_s;
         tag1_r <= adr_pipe_r[RD_LAT-1];
         val1_r <= val_pipe_r[RD_LAT-1];
         sum2_r <= {1'b0, re2_r} + {1'b0, im2_r};
         tag2_r <= tag1_r;
         val2_r <= val1_r;
         if (start_s) begin
            max_mag_r <= '0;
            max_bin_r <= M'(1);
         end else begin
            max_mag_r <= max_mag_s;
            max_bin_r <= max_bin_s;
         end
      end
   end

   // Control FSM: edge detect, address sweep, drain timer and registered report outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         done_q_r    <= 1'b0;
         armed_r     <= ~fft_done;
         drain_cnt_r <= '0;
         rd_adr      <= '0;
         busy        <= 1'b0;
         peak_valid  <= 1'b0;
         peak_bin    <= '0;
         peak_mag    <= '0;
`ifdef PEAK_NOISE_GATE_EN
         peak_found  <= 1'b0;
`endif
      end else begin
         done_q_r   <= fft_done;
         armed_r    <= armed_r | ~fft_done;
         peak_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (trig_s) begin
                  state_r <= SCAN;
                  rd_adr  <= M'(1);
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            SCAN: begin
               if (rd_adr == LAST_ADR) begin
                  state_r     <= DRAIN;
                  rd_adr      <= '0;
                  drain_cnt_r <= '0;
               end else begin
                  rd_adr <= rd_adr + M'(1);
               end
            end
            DRAIN: begin
               // the last bin's compare lands on this same edge, so report the comb max
               if (drain_cnt_r == DRAIN_END) begin
                  state_r    <= REPORT;
                  peak_valid <= 1'b1;
`ifdef PEAK_NOISE_GATE_EN
                  if (max_mag_s > noise_thresh) begin
                     peak_found <= 1'b1;
                     peak_bin   <= max_bin_s;
                     peak_mag   <= max_mag_s;
                  end else begin
                     peak_found <= 1'b0;
                     peak_bin   <= '0;
                     peak_mag   <= '0;
                  end
`else
                  peak_bin   <= max_bin_s;
                  peak_mag   <= max_mag_s;
`endif
               end else begin
                  drain_cnt_r <= drain_cnt_r + CW'(1);
               end
            end
            REPORT: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               rd_adr  <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Randomized bench for fft_peak_finder: a cycle-level reference built from the scan timing rules
// plus literal expectations for the directed spectra.
module tb_fft_peak_finder;

   localparam int BW       = 16;
   localparam int M        = 9;
   localparam int N        = 512;
   localparam int RD_LAT   = 1;
   localparam int VLD_EDGE = N/2 + RD_LAT + 1;   // peak_valid visible right after this edge

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            fft_done = 1'b0;
   logic [2*BW-1:0] fft_wd;
   logic [M-1:0]    rd_adr;
   logic            busy;
   logic            peak_valid;
   logic [M-1:0]    peak_bin;
   logic [2*BW:0]   peak_mag;
`ifdef PEAK_NOISE_GATE_EN
   logic [2*BW:0]   noise_thresh = '0;
   logic            peak_found;
`endif

   logic [2*BW-1:0] mem [N];
   int n_cmp = 0;
   int n_fail = 0;
   int pulses = 0;

   // reference model state
   int            m_e = 0;
   int            m_s = -1;
   bit            m_prev = 1'b0;
   bit            m_armed = 1'b0;
   logic [M-1:0]  m_bin = '0;
   logic [2*BW:0] m_mag = '0;
   logic          m_found = 1'b0;
   logic [M-1:0]  m_pend_bin;
   logic [2*BW:0] m_pend_mag;

   always #5 clk = ~clk;

   fft_peak_finder #(.bit_width(BW), .M(M), .N(N), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .fft_done   (fft_done),
      .fft_wd     (fft_wd),
      .rd_adr     (rd_adr),
      .busy       (busy),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag)
`ifdef PEAK_NOISE_GATE_EN
      ,
      .noise_thresh (noise_thresh),
      .peak_found   (peak_found)
`endif
   );

   // FFT result memory with one cycle of read latency
   always @(posedge clk) fft_wd <= mem[rd_adr];

   always @(negedge clk) if (peak_valid === 1'b1) pulses <= pulses + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Highest |X|^2 over bins 1..N/2-1, first occurrence wins
   function automatic void best_of(output logic [M-1:0] b, output logic [2*BW:0] m);
      longint best;
      int bi;
      logic signed [BW-1:0] r16;
      logic signed [BW-1:0] i16;
      longint re;
      longint im;
      best = 0;
      bi = 1;
      for (int k = 1; k < N/2; k++) begin
         r16 = mem[k][2*BW-1:BW];
         i16 = mem[k][BW-1:0];
         re = r16;
         im = i16;
         if (re*re + im*im > best) begin
            best = re*re + im*im;
            bi = k;
         end
      end
      b = bi[M-1:0];
      m = best[2*BW:0];
   endfunction

   // Reference timeline and per-cycle comparison of every output
   initial begin
      int d;
      forever begin
         @(posedge clk);
         m_e++;
         if (reset) begin
            m_s = -1;
            m_prev = 1'b0;
            m_armed = !fft_done;
            m_bin = '0;
            m_mag = '0;
            m_found = 1'b0;
         end else begin
            if (m_s >= 0 && m_e == m_s + VLD_EDGE) begin
`ifdef PEAK_NOISE_GATE_EN
               m_found = (m_pend_mag > noise_thresh);
               m_bin = m_found ? m_pend_bin : '0;
               m_mag = m_found ? m_pend_mag : '0;
`else
               m_bin = m_pend_bin;
               m_mag = m_pend_mag;
`endif
            end
            if (fft_done && !m_prev && m_armed && (m_s < 0 || m_e >= m_s + VLD_EDGE + 2)) begin
               m_s = m_e;
               best_of(m_pend_bin, m_pend_mag);
            end
            if (!fft_done) m_armed = 1'b1;
            m_prev = fft_done;
         end
         @(negedge clk);
         d = (m_s >= 0) ? (m_e - m_s) : -1000;
         chk("busy", busy, (d >= 0 && d <= VLD_EDGE));
         chk("peak_valid", peak_valid, (d == VLD_EDGE));
         chk("rd_adr", rd_adr, (d >= 0 && d <= N/2 - 2) ? d + 1 : 0);
         chk("peak_bin", peak_bin, m_bin);
         chk("peak_mag", peak_mag, m_mag);
`ifdef PEAK_NOISE_GATE_EN
         chk("peak_found", peak_found, m_found);
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise fft_done, drop it after 'hold' cycles, wait (bounded) for peak_valid
   task automatic do_scan(input int hold, output int vcyc);
      int n;
      fft_done = 1'b1;
      tick(1);
      n = 0;
      vcyc = -1;
      while (n < 400 && vcyc < 0) begin
         tick(1);
         n++;
         if (n >= hold) fft_done = 1'b0;
         if (peak_valid === 1'b1) vcyc = n + 1;
      end
      fft_done = 1'b0;
      if (vcyc < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scan_timeout: no peak_valid within %0d cycles, expected at cycle %0d", n, VLD_EDGE + 1);
      end
      tick(2);
   endtask

   task automatic fill_const(input logic [2*BW-1:0] v);
      for (int k = 0; k < N; k++) mem[k] = v;
   endtask

   task automatic fill_rand(input int mode);
      logic [BW-1:0] re;
      logic [BW-1:0] im;
      int a;
      for (int k = 0; k < N; k++) begin
         re = BW'($urandom);
         im = BW'($urandom);
         if (mode == 1 && k < N/2) begin
            re = BW'($urandom_range(0, 16)) - 16'd8;
            im = BW'($urandom_range(0, 16)) - 16'd8;
         end
         if (mode == 2 && k > 0 && k < N/2) begin
            re = 16'd0;
            im = 16'd0;
         end
         mem[k] = {re, im};
      end
      if (mode == 2) begin
         a = $urandom_range(1, N/2 - 1);
         mem[a] = {BW'($urandom), BW'($urandom)};
         mem[$urandom_range(1, N/2 - 1)] = mem[a];
      end
   endtask

   initial begin
      int vc;
      int p0;

      // fft_done high across reset release must not start a scan
      fill_const(32'd0);
      fft_done = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(20);
      chk("held_at_reset_busy", busy, 1'b0);
      fft_done = 1'b0;
      tick(2);

      // all-zero spectrum
      do_scan(5, vc);
`ifdef PEAK_NOISE_GATE_EN
      chk("zero_bin", peak_bin, 9'd0);
`else
      chk("zero_bin", peak_bin, 9'd1);
`endif
      chk("zero_mag", peak_mag, 33'd0);

      // single tone
      fill_const({16'd10, 16'd10});
      mem[37] = {16'd1000, 16'hFE0C};
      do_scan(3, vc);
      chk("tone_cycle", vc, 32'd259);
      chk("tone_bin", peak_bin, 9'd37);
      chk("tone_mag", peak_mag, 33'd1250000);

      // DC excluded, ties keep lowest bin
      fill_const(32'd0);
      mem[0] = {16'h7FFF, 16'h0000};
      mem[90] = {16'd300, 16'd400};
      mem[200] = {16'd300, 16'd400};
      do_scan(1, vc);
      chk("tie_bin", peak_bin, 9'd90);
      chk("tie_mag", peak_mag, 33'd250000);
`ifdef PEAK_NOISE_GATE_EN
      noise_thresh = 33'd300000;
      do_scan(4, vc);
      chk("gate_hi_found", peak_found, 1'b0);
      chk("gate_hi_bin", peak_bin, 9'd0);
      chk("gate_hi_mag", peak_mag, 33'd0);
      noise_thresh = 33'd249999;
      do_scan(4, vc);
      chk("gate_lo_found", peak_found, 1'b1);
      chk("gate_lo_bin", peak_bin, 9'd90);
      chk("gate_lo_mag", peak_mag, 33'd250000);
      noise_thresh = 33'd0;
`endif

      // most-negative components; mirror half full of large values
      fill_const({16'h7FFF, 16'h7FFF});
      mem[0] = {16'h8000, 16'h8000};
      for (int k = 1; k < N/2; k++) mem[k] = 32'd0;
      mem[255] = {16'h8000, 16'h8000};
      mem[256] = {16'h8000, 16'h8000};
      do_scan(200, vc);
      chk("ext_bin", peak_bin, 9'd255);
      chk("ext_mag", peak_mag, 33'd2147483648);

      // level held high for 2000 cycles gives exactly one report
      p0 = pulses;
      fft_done = 1'b1;
      tick(2000);
      fft_done = 1'b0;
      tick(2);
      chk("held_high_pulses", pulses - p0, 32'd1);

      // second edge at cycle 100 of a scan is ignored
      fill_rand(0);
      p0 = pulses;
      fft_done = 1'b1;
      tick(50);
      fft_done = 1'b0;
      tick(50);
      fft_done = 1'b1;
      tick(50);
      fft_done = 1'b0;
      tick(250);
      chk("retrig_pulses", pulses - p0, 32'd1);

      // reset in the middle of a scan
      fill_rand(1);
      p0 = pulses;
      fft_done = 1'b1;
      tick(11);
      fft_done = 1'b0;
      tick(109);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_adr", rd_adr, 9'd0);
      chk("rst_peak_bin", peak_bin, 9'd0);
      chk("rst_peak_mag", peak_mag, 33'd0);
      tick(300);
      chk("rst_pulses", pulses - p0, 32'd0);
      do_scan(7, vc);
      chk("post_rst_cycle", vc, 32'd259);

      // randomized spectra and hold times
      for (int it = 0; it < 9; it++) begin
         fill_rand(it % 3);
`ifdef PEAK_NOISE_GATE_EN
         noise_thresh = (it % 2 == 0) ? 33'($urandom) : 33'd0;
`endif
         do_scan($urandom_range(1, 250), vc);
         chk("rand_cycle", vc, 32'd259);
         tick($urandom_range(0, 5));
      end

      tick(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
